// File: rtl/sensor_pkg.sv
// Shared width helpers and bit-count function for the sensor phase detector.
// Pure elaboration-time / combinational helpers, no state.
// No flow control involved.
package sensor_pkg;

    // Widest word the generic popcount accepts; callers zero-extend into it.
    localparam int POP_MAX_W = 64;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Accumulator width: holds ser_width * 2^avg_log2 without overflow.
    function automatic int acc_width(input int ser_width, input int avg_log2);
        return avg_log2 + clog2(ser_width + 1);
    endfunction

    // Number of set bits in a zero-extended vector.
    function automatic int popcount(input logic [POP_MAX_W-1:0] vec);
        int n;
        n = 0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            n += int'(vec[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/sensor_nco.sv
// Phase-accumulator NCO producing one SER_WIDTH-bit drive word per clock.
// Latency: 1 cycle from phase/increment to drive word.
// No backpressure; runs every cycle while enabled, outputs zero when stopped.
module sensor_nco
    import sensor_pkg::*;
#(
    parameter int SER_WIDTH  = 8,
    parameter int PHASE_BITS = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  freq_load,
    input  logic [PHASE_BITS-1:0] freq_inc,
    input  logic                  boundary,
    output logic [SER_WIDTH-1:0]  drive
);

    localparam logic [PHASE_BITS-1:0] WORD_STEPS = PHASE_BITS'(SER_WIDTH);

    logic [PHASE_BITS-1:0] phase;
    logic [PHASE_BITS-1:0] active_inc;
    logic [PHASE_BITS-1:0] pending_inc;
    logic [PHASE_BITS-1:0] tap;
    logic [SER_WIDTH-1:0]  drive_next;

    // Each serial bit k samples the phase MSB k increments into the word.
    always_comb begin
        drive_next = '0;
        tap        = '0;
        for (int k = 0; k < SER_WIDTH; k++) begin
            tap           = phase + PHASE_BITS'(k) * active_inc;
            drive_next[k] = tap[PHASE_BITS-1];
        end
    end

    // Shadow register: holds the most recently loaded increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending_inc <= '0;
        else if (freq_load) pending_inc <= freq_inc;
    end

    // Increment only changes between windows or while stopped; a load in the
    // same cycle bypasses the shadow so it governs the very next window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) active_inc <= '0;
        else if (!enable || boundary) active_inc <= freq_load ? freq_inc : pending_inc;
    end

    // Phase advances one word per cycle when running; drive forced low when stopped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= '0;
            drive <= '0;
        end else if (enable) begin
            phase <= phase + WORD_STEPS * active_inc;
            drive <= drive_next;
        end else begin
            drive <= '0;
        end
    end

endmodule

// File: rtl/sensor_phase_detector.sv
// Drive NCO plus per-channel sense^ref mismatch counter integrated over 2^AVG_LOG2 words.
// Latency: last window word at cycle t -> RESULT/RESULT_VALID at cycle t+3; drive 1 cycle.
// No backpressure; one word per channel per cycle, partial windows dropped on ENABLE=0.
module sensor_phase_detector
    import sensor_pkg::*;
#(
    parameter  int SER_WIDTH  = 8,
    parameter  int CHANNELS   = 2,
    parameter  int PHASE_BITS = 32,
    parameter  int AVG_LOG2   = 4,
    localparam int ACC_W      = acc_width(SER_WIDTH, AVG_LOG2)
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          ENABLE,
    input  logic [PHASE_BITS-1:0]         FREQ_INC,
    input  logic                          FREQ_LOAD,
    output logic [SER_WIDTH-1:0]          DRIVE_OUT,
    input  logic [SER_WIDTH-1:0]          REF_IN,
    input  logic [CHANNELS*SER_WIDTH-1:0] SENSE_IN,
    output logic [CHANNELS*ACC_W-1:0]     RESULT,
    output logic                          RESULT_VALID
);

    localparam int CNT_W = clog2(SER_WIDTH + 1);

    logic                v1;
    logic                v2;
    logic [AVG_LOG2-1:0] win_cnt;
    logic                boundary;

    // The word at S3 that wraps the window counter closes the window.
    assign boundary = v2 && (win_cnt == '1);

    sensor_nco #(
        .SER_WIDTH (SER_WIDTH),
        .PHASE_BITS(PHASE_BITS)
    ) u_nco (
        .clk      (CLK),
        .rst      (RESET),
        .enable   (ENABLE),
        .freq_load(FREQ_LOAD),
        .freq_inc (FREQ_INC),
        .boundary (boundary),
        .drive    (DRIVE_OUT)
    );

    // Valid bit follows the data through S1 and S2.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v1 <= ENABLE;
            v2 <= v1;
        end
    end

    // Window position; an invalid word at S3 restarts the window.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) win_cnt <= '0;
        else if (!v2) win_cnt <= '0;
        else win_cnt <= win_cnt + AVG_LOG2'(1);
    end

    // Single-cycle strobe on each completed window.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) RESULT_VALID <= 1'b0;
        else RESULT_VALID <= boundary;
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic [SER_WIDTH-1:0] x_q;
        logic [CNT_W-1:0]     cnt_q;
        logic [ACC_W-1:0]     acc_q;
        logic [ACC_W-1:0]     result_q;

        // S1: bits where this sense stream disagrees with ref.
        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) x_q <= '0;
            else x_q <= SENSE_IN[c*SER_WIDTH +: SER_WIDTH] ^ REF_IN;
        end

        // S2: mismatch count for the word.
        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) cnt_q <= '0;
            else cnt_q <= CNT_W'(popcount(POP_MAX_W'(x_q)));
        end

        // S3: integrate; publish and clear at window end, discard on dropout.
        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                acc_q    <= '0;
                result_q <= '0;
            end else if (!v2) begin
                acc_q <= '0;
            end else if (boundary) begin
                result_q <= acc_q + ACC_W'(cnt_q);
                acc_q    <= '0;
            end else begin
                acc_q <= acc_q + ACC_W'(cnt_q);
            end
        end

        assign RESULT[c*ACC_W +: ACC_W] = result_q;
    end

endmodule

// File: tb/tb_sensor_phase_detector.sv
module tb_sensor_phase_detector;

    localparam int WIN = 16;
    localparam int HN  = 4096;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        ENABLE = 1'b0;
    logic        FREQ_LOAD = 1'b0;
    logic [31:0] FREQ_INC = '0;
    logic [7:0]  REF_IN = '0;
    logic [15:0] SENSE_IN = '0;
    logic [7:0]  DRIVE_OUT;
    logic [15:0] RESULT;
    logic        RESULT_VALID;

    always #5 CLK = ~CLK;

    sensor_phase_detector #(
        .SER_WIDTH(8), .CHANNELS(2), .PHASE_BITS(32), .AVG_LOG2(4)
    ) dut (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .FREQ_INC(FREQ_INC),
        .FREQ_LOAD(FREQ_LOAD), .DRIVE_OUT(DRIVE_OUT), .REF_IN(REF_IN),
        .SENSE_IN(SENSE_IN), .RESULT(RESULT), .RESULT_VALID(RESULT_VALID)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Windows are runs of consecutive enabled words since the last dropout
    // or reset; a window closes when the run length reaches a multiple of 16,
    // and its result is the plain sum of the last 16 words' mismatch counts.
    int          n = 0;
    int          base = 0;
    int          run_h [HN];
    int          m0_h  [HN];
    int          m1_h  [HN];
    logic [31:0] m_phase = '0;
    logic [31:0] m_active = '0;
    logic [31:0] m_pending = '0;
    logic [7:0]  exp_drive = '0;
    logic [15:0] exp_result = '0;
    logic        exp_valid = 1'b0;

    function automatic logic [7:0] nco_word(input logic [31:0] ph, input logic [31:0] inc);
        logic [31:0] p;
        logic [7:0]  w;
        w = '0;
        for (int k = 0; k < 8; k++) begin
            p    = ph + 32'(k) * inc;
            w[k] = p[31];
        end
        return w;
    endfunction

    function automatic bit window_ends(input int w);
        return (w >= base) && (run_h[w] > 0) && (run_h[w] % WIN == 0);
    endfunction

    function automatic int window_sum(input int w, input int ch);
        int s;
        s = 0;
        for (int i = 0; i < WIN; i++) s += (ch == 1) ? m1_h[w-i] : m0_h[w-i];
        return s;
    endfunction

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            base       <= n;
            exp_drive  <= '0;
            exp_valid  <= 1'b0;
            exp_result <= '0;
            m_phase    <= '0;
            m_active   <= '0;
            m_pending  <= '0;
        end else begin
            run_h[n] <= ENABLE ? ((n > base) ? run_h[n-1] + 1 : 1) : 0;
            m0_h[n]  <= $countones(SENSE_IN[7:0] ^ REF_IN);
            m1_h[n]  <= $countones(SENSE_IN[15:8] ^ REF_IN);
            exp_valid <= window_ends(n - 2);
            if (window_ends(n - 2))
                exp_result <= {8'(window_sum(n - 2, 1)), 8'(window_sum(n - 2, 0))};
            exp_drive <= ENABLE ? nco_word(m_phase, m_active) : 8'h00;
            if (ENABLE) m_phase <= m_phase + 32'd8 * m_active;
            if (!ENABLE || window_ends(n - 2)) m_active <= FREQ_LOAD ? FREQ_INC : m_pending;
            if (FREQ_LOAD) m_pending <= FREQ_INC;
            n <= n + 1;
        end
    end

    // ---------------- stimulus helpers ----------------
    int          pulses;
    logic [15:0] last_res;

    task automatic step();
        @(posedge CLK);
        #1;
        check("drive_out", DRIVE_OUT, exp_drive);
        check("result_valid", RESULT_VALID, exp_valid);
        check("result", RESULT, exp_result);
        if (RESULT_VALID) begin
            pulses++;
            last_res = RESULT;
        end
    endtask

    task automatic drive_in(input logic en, input logic fl, input logic [31:0] finc,
                            input logic [7:0] x0, input logic [7:0] x1);
        logic [7:0] r;
        r         = 8'($urandom);
        ENABLE    = en;
        FREQ_LOAD = fl;
        FREQ_INC  = finc;
        REF_IN    = r;
        SENSE_IN  = {r ^ x1, r ^ x0};
    endtask

    typedef struct {
        logic        en;
        logic        fl;
        logic [31:0] finc;
        logic [7:0]  x0;
        logic [7:0]  x1;
        int          len;
        int          pulses;
        logic [7:0]  r0;
        logic [7:0]  r1;
        logic        chk_drv;
        logic [7:0]  drv;
    } seg_t;

    seg_t segs [14];

    initial begin
        // {en, fl, finc, x0, x1, len, pulses, r0, r1, chk_drv, drv}
        segs[0]  = '{1'b0, 1'b1, 32'h1000_0000, 8'h00, 8'h00,  1, 0, 8'd0,   8'd0,   1'b1, 8'h00};
        segs[1]  = '{1'b0, 1'b0, 32'h0,         8'h00, 8'h00,  2, 0, 8'd0,   8'd0,   1'b1, 8'h00};
        segs[2]  = '{1'b1, 1'b0, 32'h0,         8'h00, 8'hFF, 16, 0, 8'd0,   8'd0,   1'b1, 8'hFF};
        segs[3]  = '{1'b1, 1'b0, 32'h0,         8'h0F, 8'h01,  2, 1, 8'd0,   8'd128, 1'b0, 8'h00};
        segs[4]  = '{1'b1, 1'b0, 32'h0,         8'h0F, 8'h01,  5, 0, 8'd0,   8'd0,   1'b0, 8'h00};
        segs[5]  = '{1'b1, 1'b1, 32'h0800_0000, 8'h0F, 8'h01,  1, 0, 8'd0,   8'd0,   1'b0, 8'h00};
        segs[6]  = '{1'b1, 1'b0, 32'h0,         8'h0F, 8'h01, 18, 1, 8'd64,  8'd16,  1'b0, 8'h00};
        segs[7]  = '{1'b0, 1'b0, 32'h0,         8'h0F, 8'h01,  3, 0, 8'd0,   8'd0,   1'b1, 8'h00};
        segs[8]  = '{1'b1, 1'b0, 32'h0,         8'hFF, 8'h00, 20, 1, 8'd128, 8'd0,   1'b0, 8'h00};
        segs[9]  = '{1'b1, 1'b0, 32'h0,         8'h3C, 8'h00, 11, 0, 8'd0,   8'd0,   1'b0, 8'h00};
        segs[10] = '{1'b1, 1'b1, 32'h0400_0000, 8'h3C, 8'h00,  1, 0, 8'd0,   8'd0,   1'b0, 8'h00};
        segs[11] = '{1'b1, 1'b0, 32'h0,         8'h3C, 8'h00,  1, 0, 8'd0,   8'd0,   1'b0, 8'h00};
        segs[12] = '{1'b1, 1'b1, 32'h2000_0000, 8'h3C, 8'h00,  1, 1, 8'd80,  8'd0,   1'b0, 8'h00};
        segs[13] = '{1'b1, 1'b0, 32'h0,         8'h3C, 8'h00, 24, 1, 8'd64,  8'd0,   1'b0, 8'h00};

        // Reset state, observed between clock edges.
        #12;
        check("reset_drive", DRIVE_OUT, 8'h00);
        check("reset_result", RESULT, 16'h0000);
        check("reset_valid", RESULT_VALID, 1'b0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;

        // Directed scenarios, table driven.
        for (int s = 0; s < 14; s++) begin
            pulses = 0;
            for (int j = 0; j < segs[s].len; j++) begin
                drive_in(segs[s].en, segs[s].fl, segs[s].finc, segs[s].x0, segs[s].x1);
                step();
            end
            check($sformatf("seg%0d_pulses", s), pulses, segs[s].pulses);
            if (segs[s].pulses > 0) begin
                check($sformatf("seg%0d_result0", s), last_res[7:0], segs[s].r0);
                check($sformatf("seg%0d_result1", s), last_res[15:8], segs[s].r1);
            end
            if (segs[s].chk_drv)
                check($sformatf("seg%0d_drive", s), DRIVE_OUT, segs[s].drv);
        end

        // Asynchronous reset mid-run, observed with no clock edge.
        check("pre_reset_result_nonzero", RESULT != 16'h0, 1'b1);
        check("pre_reset_drive_nonzero", DRIVE_OUT != 8'h0, 1'b1);
        #3;
        RESET = 1'b1;
        #1;
        check("async_reset_drive", DRIVE_OUT, 8'h00);
        check("async_reset_result", RESULT, 16'h0000);
        check("async_reset_valid", RESULT_VALID, 1'b0);
        drive_in(1'b0, 1'b0, 32'h0, 8'h00, 8'h00);
        step();
        step();
        RESET = 1'b0;
        pulses = 0;
        for (int j = 0; j < 5; j++) begin
            drive_in(1'b0, 1'b0, 32'h0, 8'h55, 8'hAA);
            step();
        end
        check("idle_after_reset_drive", DRIVE_OUT, 8'h00);
        check("idle_after_reset_result", RESULT, 16'h0000);
        check("idle_after_reset_pulses", pulses, 0);

        // Randomized traffic against the model, with one extra async reset.
        for (int i = 0; i < 1500; i++) begin
            ENABLE    = ($urandom_range(0, 24) != 0);
            FREQ_LOAD = ($urandom_range(0, 39) == 0);
            FREQ_INC  = $urandom;
            REF_IN    = 8'($urandom);
            SENSE_IN  = 16'($urandom);
            if ((i % 100) < 20) SENSE_IN = {~REF_IN, REF_IN};
            if (i == 700) begin
                #3;
                RESET = 1'b1;
                #1;
                RESET = 1'b0;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sensor_phase_detector.md
# sensor_phase_detector

Parametrised successor to the fixed 8-bit drive/ref/sense serializer datapath of the theremin sensor front end. The block sits in the parallel clock domain between the ODDR/IDDR serializers and downstream pitch/volume processing.
- It generates the AFE drive bit stream from a programmable NCO.
- It XOR-compares each of CHANNELS deserialised sense streams against the deserialised ref stream.
- It reports per-channel mismatch counts, integrated over a window of 2^AVG_LOG2 parallel words.

## Interface
Parameters:
- SER_WIDTH, 8: bits per parallel word; bit 0 is the earliest bit in time.
- CHANNELS, 2: number of sense inputs.
- PHASE_BITS, 32: NCO phase accumulator width.
- AVG_LOG2, 4: log2 of the number of words per integration window.
- ACC_W is derived: AVG_LOG2 + clog2(SER_WIDTH+1).

Ports:
- CLK, in, 1: parallel (slow) clock. This is the only clock.
- RESET, in, 1: asynchronous, active-high reset.
- ENABLE, in, 1: run/stop control.
- FREQ_INC, in, PHASE_BITS: phase increment per serial bit.
- FREQ_LOAD, in, 1: one-cycle strobe that captures FREQ_INC.
- DRIVE_OUT, out, SER_WIDTH: drive word to the ODDR.
- REF_IN, in, SER_WIDTH: ref word from the IDDR.
- SENSE_IN, in, CHANNELS*SER_WIDTH: sense words; channel c occupies slice [c*SER_WIDTH +: SER_WIDTH].
- RESULT, out, CHANNELS*ACC_W: per-channel window mismatch count; channel c occupies slice [c*ACC_W +: ACC_W].
- RESULT_VALID, out, 1: one-cycle strobe marking a new RESULT.

## Operation
- Reset values: phase=0, active_inc=0, pending_inc=0, DRIVE_OUT=0, all pipeline registers and valid bits=0, window counter=0, all accumulators=0, RESULT=0, RESULT_VALID=0.
- FREQ_LOAD: pending_inc <= FREQ_INC.
  - active_inc <= pending_inc at a window boundary (the cycle the last word of a window is accumulated).
  - active_inc <= pending_inc on any cycle with ENABLE=0.
  - If FREQ_LOAD coincides with a boundary, FREQ_INC is applied directly (bypass). It governs the next window.
- NCO, when ENABLE=1, each cycle:
  - DRIVE_OUT[k] <= MSB(phase + k*active_inc).
  - phase <= phase + SER_WIDTH*active_inc, modulo 2^PHASE_BITS. Wrap-around is silent.
- NCO, when ENABLE=0: phase holds and DRIVE_OUT <= 0.
- Detector pipeline. A valid bit equal to registered ENABLE travels with the data.
  - S1: register x_c = SENSE_IN_c ^ REF_IN.
  - S2: register popcount(x_c), width clog2(SER_WIDTH+1).
  - S3: if S2 is valid, acc_c += count. The window counter increments, wrapping at 2^AVG_LOG2.
- Window completion: on the cycle the word that wraps the counter is accumulated:
  - RESULT_c <= acc_c + count;
  - acc_c <= 0;
  - RESULT_VALID <= 1 for exactly one cycle.
- Width: ACC_W holds the maximum SER_WIDTH*2^AVG_LOG2, so no overflow handling is required.
- ENABLE=0 at S3 input: the window counter and accumulators clear, no RESULT_VALID is issued, and RESULT holds its last value. A partial window is discarded, never reported.
- ENABLE re-asserted: the first window begins with the first valid word reaching S3.
- RESET asserted mid-window: all state returns to reset values immediately.

## Timing
- Phase update to DRIVE_OUT: 1 cycle. The first non-zero-phase word appears 2 cycles after ENABLE rises.
- Input to result: the last word of a window present on REF_IN/SENSE_IN at cycle t gives RESULT and RESULT_VALID asserted at cycle t+3.
- RESULT_VALID period under continuous ENABLE: exactly 2^AVG_LOG2 cycles.
- Throughput: one word per channel per cycle, with no backpressure.
- Frequency change: a FREQ_LOAD is visible on DRIVE_OUT 1 cycle after the boundary (or after the load, if ENABLE=0).

## Structure
- Package sensor_pkg contains:
  - clog2 function;
  - derived-width function for ACC_W;
  - popcount function (generic over width).
- Sub-module sensor_nco: phase accumulator, increment shadow/active registers, and DRIVE_OUT generation. It receives a boundary pulse from the detector.
- Per-channel popcount/accumulate logic is a generate loop in the top; there is no separate module.

## Test plan
All scenarios use defaults: SER_WIDTH=8, CHANNELS=2, AVG_LOG2=4, ACC_W=8.
- Reset: assert RESET asynchronously mid-run -> DRIVE_OUT=0x00, RESULT=0, RESULT_VALID=0 with no clock edge. After release with ENABLE=0, everything stays 0.
- NCO: ENABLE=0, FREQ_INC=0x10000000 with FREQ_LOAD, then ENABLE=1 -> DRIVE_OUT sequence 0x00, 0xFF, 0x00, 0xFF, ... (period of 16 bits). Then FREQ_INC=0x08000000 loaded mid-window -> the pattern changes to 0x00, 0x00, 0xFF, 0xFF only 1 cycle after the next boundary.
- Full-scale detector: SENSE_IN_0=REF_IN and SENSE_IN_1=~REF_IN for 16 words -> RESULT_0=0 and RESULT_1=128, with RESULT_VALID pulsed at t+3 after the 16th word.
- Partial mismatch: SENSE_0=REF^0x0F and SENSE_1=REF^0x01 -> RESULT_0=64 and RESULT_1=16 every 16 cycles, with a single-cycle RESULT_VALID each time.
- ENABLE dropout: ENABLE low for 3 cycles after 10 words -> no RESULT_VALID and RESULT unchanged. The next RESULT_VALID arrives 16 valid words after re-enable and reflects only post-enable data.
- Simultaneous FREQ_LOAD at boundary: load 0x20000000 on the boundary cycle -> the next window's DRIVE_OUT uses the new increment (period of 8 bits: 0x0F, 0x0F, ...). The previous pending value is never applied.
